// File: rtl/game_pkg.sv
// Shared game-level types: game FSM encodings, spawn scheduler states, LFSR constants.
package game_pkg;

   localparam logic [2:0] GAME_INIT    = 3'b000;
   localparam logic [2:0] GAME_IDLE    = 3'b001;
   localparam logic [2:0] GAME_PLAYING = 3'b010;
   localparam logic [2:0] GAME_OVER    = 3'b100;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StPick,
      StIssue,
      StStall
   } sched_state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 mapped onto bits 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic lfsr_feedback(input logic [15:0] state);
      return ^(state & LFSR_TAPS);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; only hard_reset reseeds it so game restarts keep the sequence going.
module lfsr16
   import game_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_SEED
) (
   input  logic        clk,
   input  logic        hard_reset,
   input  logic        i_en,
   output logic [15:0] o_lfsr
);

   logic [15:0] r_lfsr;

   always_ff @(posedge clk or posedge hard_reset) begin
      if (hard_reset) begin
         r_lfsr <= SEED;
      end else if (i_en) begin
         r_lfsr <= {r_lfsr[14:0], lfsr_feedback(r_lfsr)};
      end
   end

   assign o_lfsr = r_lfsr;

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// Frame-paced obstacle spawner: round-robin slot allocation, lane choice, difficulty ramp.
// Define SPAWN_RANDOM_EN to draw lanes from an LFSR instead of a handshake counter.
module obstacle_spawn_scheduler
   import game_pkg::*;
#(
   parameter int unsigned NUM_SLOTS        = 4,
   parameter int unsigned LANE_W           = 3,
   parameter int unsigned INIT_INTERVAL    = 90,
   parameter int unsigned MIN_INTERVAL     = 30,
   parameter int unsigned STEP             = 6,
   parameter int unsigned SPAWNS_PER_LEVEL = 8,
   parameter int unsigned LEVEL_W          = 4
) (
   input  logic                 clk,
   input  logic                 hard_reset,
   input  logic                 i_game_reset,
   input  logic                 i_game_en,
   input  logic                 i_frame_tick,
   input  logic [NUM_SLOTS-1:0] i_slot_busy,
   input  logic                 i_spawn_ready,
   output logic                 o_spawn_valid,
   output logic [NUM_SLOTS-1:0] o_spawn_slot,
   output logic [LANE_W-1:0]    o_spawn_lane,
   output logic [LEVEL_W-1:0]   o_level,
   output logic [7:0]           o_interval
);

   localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
   localparam int unsigned CNT_W = $clog2(SPAWNS_PER_LEVEL + 1);
   localparam logic [7:0] INIT_IV = 8'(INIT_INTERVAL);
   localparam logic [7:0] MIN_IV  = 8'(MIN_INTERVAL);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   sched_state_e          r_state, w_state_next;
   logic [7:0]            r_frame_cnt, w_frame_cnt_next;
   logic [IDX_W-1:0]      r_rr, w_rr_next;
   logic [IDX_W-1:0]      r_slot_idx, w_slot_idx_next;
   logic [NUM_SLOTS-1:0]  r_slot, w_slot_next;
   logic [LANE_W-1:0]     r_lane, w_lane_next, w_lane_src;
   logic [CNT_W-1:0]      r_spawn_cnt, w_spawn_cnt_next;
   logic [LEVEL_W-1:0]    r_level, w_level_next;
   logic [7:0]            r_interval, w_interval_next;
   logic                  w_valid, w_handshake, w_found;
   logic [IDX_W-1:0]      w_free_idx;
   logic signed [8:0]     w_iv_dec;
   logic [7:0]            w_iv_floor;

   // First free slot scanning upward from start, wrapping; MSB flags success.
   function automatic logic [IDX_W:0] find_free(input logic [NUM_SLOTS-1:0] busy,
                                                input logic [IDX_W-1:0]     start);
      logic [IDX_W:0] res;
      int             j;
      res = '0;
      for (int k = int'(NUM_SLOTS) - 1; k >= 0; k--) begin
         j = int'(start) + k;
         if (j >= int'(NUM_SLOTS)) j = j - int'(NUM_SLOTS);
         if (!busy[IDX_W'(j)]) res = {1'b1, IDX_W'(j)};
      end
      return res;
   endfunction

   assign w_valid     = (r_state == StIssue) & i_game_en;
   assign w_handshake = w_valid & i_spawn_ready;
   assign {w_found, w_free_idx} = find_free(i_slot_busy, r_rr);

   assign w_iv_dec   = $signed({1'b0, r_interval}) - $signed(9'(STEP));
   assign w_iv_floor = (w_iv_dec < $signed({1'b0, MIN_IV})) ? MIN_IV : w_iv_dec[7:0];

`ifdef SPAWN_RANDOM_EN
   logic [15:0] w_lfsr;
   logic        w_unused_lfsr;

   lfsr16 #(
      .SEED(LFSR_SEED)
   ) u_lfsr (
      .clk       (clk),
      .hard_reset(hard_reset),
      .i_en      (1'b1),
      .o_lfsr    (w_lfsr)
   );

   assign w_lane_src    = w_lfsr[LANE_W-1:0];
   assign w_unused_lfsr = ^w_lfsr;
`else
   logic [LANE_W-1:0] r_hs_cnt;

   always_ff @(posedge clk or posedge hard_reset) begin
      if (hard_reset) begin
         r_hs_cnt <= '0;
      end else if (i_game_reset) begin
         r_hs_cnt <= '0;
      end else if (w_handshake) begin
         r_hs_cnt <= r_hs_cnt + LANE_W'(1);
      end
   end

   assign w_lane_src = r_hs_cnt;
`endif

   always_comb begin
      w_state_next     = r_state;
      w_frame_cnt_next = r_frame_cnt;
      w_rr_next        = r_rr;
      w_slot_idx_next  = r_slot_idx;
      w_slot_next      = r_slot;
      w_lane_next      = r_lane;
      w_spawn_cnt_next = r_spawn_cnt;
      w_level_next     = r_level;
      w_interval_next  = r_interval;

      if (i_game_reset) begin
         w_state_next     = StIdle;
         w_frame_cnt_next = '0;
         w_rr_next        = '0;
         w_slot_idx_next  = '0;
         w_slot_next      = '0;
         w_lane_next      = '0;
         w_spawn_cnt_next = '0;
         w_level_next     = '0;
         w_interval_next  = INIT_IV;
      end else if (!i_game_en) begin
         // Level and interval survive so the game-over screen can show them.
         w_state_next     = StIdle;
         w_frame_cnt_next = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               w_state_next     = StWait;
               w_frame_cnt_next = '0;
            end
            StWait: begin
               if (i_frame_tick) begin
                  if (r_frame_cnt + 8'd1 == r_interval) begin
                     w_frame_cnt_next = '0;
                     w_state_next     = StPick;
                  end else begin
                     w_frame_cnt_next = r_frame_cnt + 8'd1;
                  end
               end
            end
            StPick: begin
               if (w_found) begin
                  w_slot_idx_next = w_free_idx;
                  w_slot_next     = NUM_SLOTS'(1) << w_free_idx;
                  w_lane_next     = w_lane_src;
                  w_state_next    = StIssue;
               end else begin
                  w_state_next = StStall;
               end
            end
            StStall: begin
               if (!(&i_slot_busy)) w_state_next = StPick;
            end
            StIssue: begin
               if (w_handshake) begin
                  w_rr_next    = (r_slot_idx == IDX_W'(NUM_SLOTS - 1)) ? '0
                                                                        : r_slot_idx + IDX_W'(1);
                  w_state_next = StWait;
                  if (r_spawn_cnt == CNT_W'(SPAWNS_PER_LEVEL - 1)) begin
                     w_spawn_cnt_next = '0;
                     w_level_next     = (r_level == LEVEL_MAX) ? r_level : r_level + LEVEL_W'(1);
                     w_interval_next  = w_iv_floor;
                  end else begin
                     w_spawn_cnt_next = r_spawn_cnt + CNT_W'(1);
                  end
               end
            end
            default: w_state_next = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge hard_reset) begin
      if (hard_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or posedge hard_reset) begin
      if (hard_reset) begin
         r_frame_cnt <= '0;
         r_rr        <= '0;
         r_slot_idx  <= '0;
         r_slot      <= '0;
         r_lane      <= '0;
         r_spawn_cnt <= '0;
         r_level     <= '0;
         r_interval  <= INIT_IV;
      end else begin
         r_frame_cnt <= w_frame_cnt_next;
         r_rr        <= w_rr_next;
         r_slot_idx  <= w_slot_idx_next;
         r_slot      <= w_slot_next;
         r_lane      <= w_lane_next;
         r_spawn_cnt <= w_spawn_cnt_next;
         r_level     <= w_level_next;
         r_interval  <= w_interval_next;
      end
   end

   assign o_spawn_valid = w_valid;
   assign o_spawn_slot  = r_slot;
   assign o_spawn_lane  = r_lane;
   assign o_level       = r_level;
   assign o_interval    = r_interval;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Bench for obstacle_spawn_scheduler: vector table, directed corner sequences, random vs model.
module tb_obstacle_spawn_scheduler;

   localparam int NS = 4;

   logic       clk = 1'b0;
   logic       hard_reset = 1'b1;
   logic       game_reset, game_en, frame_tick, spawn_ready;
   logic [3:0] slot_busy;
   logic       spawn_valid;
   logic [3:0] spawn_slot;
   logic [2:0] spawn_lane;
   logic [3:0] level;
   logic [7:0] interval;

   obstacle_spawn_scheduler dut (
      .clk          (clk),
      .hard_reset   (hard_reset),
      .i_game_reset (game_reset),
      .i_game_en    (game_en),
      .i_frame_tick (frame_tick),
      .i_slot_busy  (slot_busy),
      .i_spawn_ready(spawn_ready),
      .o_spawn_valid(spawn_valid),
      .o_spawn_slot (spawn_slot),
      .o_spawn_lane (spawn_lane),
      .o_level      (level),
      .o_interval   (interval)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 off, 1 counting frames, 2 choosing, 3 offering, 4 all slots full.
   int          m_ph, m_frames, m_rr, m_total, m_slot, m_lane;
   logic [15:0] m_lfsr;

   function automatic int m_level();
      int lv = m_total / 8;
      return (lv > 15) ? 15 : lv;
   endfunction

   function automatic int m_interval();
      int iv = 90 - 6 * (m_total / 8);
      return (iv < 30) ? 30 : iv;
   endfunction

   task automatic model_hreset();
      m_ph = 0; m_frames = 0; m_rr = 0; m_total = 0; m_slot = -1; m_lane = 0;
      m_lfsr = 16'hACE1;
   endtask

   task automatic model_step();
      bit          hs;
      logic [15:0] lf_now;
      int          f;
      hs     = (m_ph == 3) && game_en && spawn_ready;
      lf_now = m_lfsr;
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (game_reset) begin
         m_ph = 0; m_frames = 0; m_rr = 0; m_total = 0; m_slot = -1; m_lane = 0;
         return;
      end
      if (!game_en) begin
         m_ph = 0; m_frames = 0;
         return;
      end
      case (m_ph)
         0: begin m_ph = 1; m_frames = 0; end
         1: if (frame_tick) begin
               m_frames++;
               if (m_frames == m_interval()) begin m_frames = 0; m_ph = 2; end
            end
         2: begin
               f = -1;
               for (int k = 0; k < NS; k++) begin
                  if (f < 0 && !slot_busy[(m_rr + k) % NS]) f = (m_rr + k) % NS;
               end
               if (f < 0) m_ph = 4;
               else begin
                  m_slot = f;
`ifdef SPAWN_RANDOM_EN
                  m_lane = int'(lf_now[2:0]);
`else
                  m_lane = m_total % 8;
`endif
                  m_ph = 3;
               end
            end
         3: if (hs) begin m_rr = (m_slot + 1) % NS; m_total++; m_ph = 1; end
         4: if (slot_busy != 4'hF) m_ph = 2;
         default: m_ph = 0;
      endcase
   endtask

   task automatic check_model();
      check("rnd_valid", spawn_valid, (m_ph == 3 && game_en) ? 1 : 0);
      check("rnd_slot", spawn_slot, (m_slot < 0) ? 0 : (1 << m_slot));
      check("rnd_lane", spawn_lane, m_lane);
      check("rnd_level", level, m_level());
      check("rnd_interval", interval, m_interval());
   endtask

   // One clock: model consumes this cycle's inputs; returns at the next falling edge.
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_spawn();
      bit got = 0;
      frame_tick = 1; spawn_ready = 1; slot_busy = 4'h0;
      for (int c = 0; c < 400 && !got; c++) begin
         #1;
         if (spawn_valid) got = 1;
         cyc();
      end
      frame_tick = 0; spawn_ready = 0;
      if (!got) check("spawn_timeout", 0, 1);
   endtask

   typedef struct {
      logic [3:0] busy;
      logic [3:0] slot;
      int         lane;
      int         lvl;
      int         iv;
   } vec_t;

   vec_t tbl[8];
   int   off_cnt;
   bit   got;

   initial begin
      tbl[0] = '{4'b0000, 4'b0001, 0, 0, 90};
      tbl[1] = '{4'b0000, 4'b0010, 1, 0, 90};
      tbl[2] = '{4'b0100, 4'b1000, 2, 0, 90};
      tbl[3] = '{4'b0001, 4'b0010, 3, 0, 90};
      tbl[4] = '{4'b1100, 4'b0001, 4, 0, 90};
      tbl[5] = '{4'b1110, 4'b0001, 5, 0, 90};
      tbl[6] = '{4'b0011, 4'b0100, 6, 0, 90};
      tbl[7] = '{4'b0111, 4'b1000, 7, 1, 84};

      game_reset = 0; game_en = 0; frame_tick = 0; slot_busy = 0; spawn_ready = 0;
      model_hreset();
      @(negedge clk);
      @(negedge clk);
      hard_reset = 0;
      #1;
      check("rst_valid", spawn_valid, 0);
      check("rst_slot", spawn_slot, 0);
      check("rst_lane", spawn_lane, 0);
      check("rst_level", level, 0);
      check("rst_interval", interval, 90);

      game_reset = 1; game_en = 1;
      cyc();
      game_reset = 0;
      cyc();

      for (int i = 0; i < 8; i++) begin
         slot_busy = tbl[i].busy; frame_tick = 1; spawn_ready = 0;
         repeat (90) cyc();
         frame_tick = 0;
         #1 check("tbl_pick_valid", spawn_valid, 0);
         cyc();
         #1;
         check("tbl_valid", spawn_valid, 1);
         check("tbl_slot", spawn_slot, tbl[i].slot);
`ifndef SPAWN_RANDOM_EN
         check("tbl_lane", spawn_lane, tbl[i].lane);
`else
         check("tbl_lane", spawn_lane, m_lane);
`endif
         slot_busy = ~tbl[i].busy;
         #1 check("tbl_slot_hold", spawn_slot, tbl[i].slot);
         spawn_ready = 1;
         cyc();
         spawn_ready = 0;
         #1;
         check("tbl_valid_drop", spawn_valid, 0);
         check("tbl_level", level, tbl[i].lvl);
         check("tbl_interval", interval, tbl[i].iv);
      end

      // All slots full at PICK, then slot 2 frees.
      slot_busy = 4'hF; frame_tick = 1;
      repeat (84) cyc();
      frame_tick = 0;
      #1 check("stall_pick", spawn_valid, 0);
      cyc();
      #1 check("stall_a", spawn_valid, 0);
      cyc();
      #1 check("stall_b", spawn_valid, 0);
      slot_busy = 4'b1011;
      cyc();
      #1 check("stall_repick", spawn_valid, 0);
      cyc();
      #1;
      check("stall_valid", spawn_valid, 1);
      check("stall_slot", spawn_slot, 4'b0100);

      // game_en falls while offering: no handshake even with ready high.
      game_en = 0; spawn_ready = 1;
      #1 check("en_drop_valid", spawn_valid, 0);
      cyc();
      spawn_ready = 0;
      #1;
      check("en_off_valid", spawn_valid, 0);
      check("en_off_level", level, 1);
      check("en_off_interval", interval, 84);
      game_en = 1;
      cyc();
      repeat (7) do_spawn();
      check("cnt_kept_level", level, 1);
      do_spawn();
      check("lvl2_level", level, 2);
      check("lvl2_interval", interval, 78);

      game_reset = 1;
      cyc();
      game_reset = 0;
      #1;
      check("grst_level", level, 0);
      check("grst_interval", interval, 90);
      check("grst_slot", spawn_slot, 0);
      check("grst_lane", spawn_lane, 0);
      cyc();

      repeat (72) do_spawn();
      check("s72_level", level, 9);
      check("s72_interval", interval, 36);
      repeat (8) do_spawn();
      check("s80_level", level, 10);
      check("s80_interval", interval, 30);
      repeat (8) do_spawn();
      check("s88_level", level, 11);
      check("s88_interval", interval, 30);
      repeat (40) do_spawn();
      check("s128_level", level, 15);
      repeat (8) do_spawn();
      check("s136_level_sat", level, 15);
      check("s136_interval", interval, 30);

      // Asynchronous hard reset while a request is offered.
      frame_tick = 1; spawn_ready = 0; slot_busy = 4'h0; got = 0;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (spawn_valid) begin got = 1; break; end
         cyc();
      end
      check("hrst_reach_issue", got, 1);
      hard_reset = 1;
      #1;
      check("hrst_valid", spawn_valid, 0);
      check("hrst_slot", spawn_slot, 0);
      check("hrst_lane", spawn_lane, 0);
      check("hrst_level", level, 0);
      check("hrst_interval", interval, 90);
      model_hreset();
      @(negedge clk);
      hard_reset = 0;

      off_cnt = 0;
      for (int n = 0; n < 30000; n++) begin
         game_reset = ($urandom_range(2999) == 0);
         if (off_cnt == 0 && $urandom_range(1499) == 0) off_cnt = $urandom_range(4, 1);
         game_en = (off_cnt == 0);
         if (off_cnt > 0) off_cnt--;
         frame_tick  = ($urandom_range(9) != 0);
         slot_busy   = 4'($urandom_range(15));
         spawn_ready = ($urandom_range(2) != 0);
         #1 check_model();
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/obstacle_spawn_scheduler.md
# obstacle_spawn_scheduler

Sequences obstacle spawning during gameplay. Paces spawns by frame count, allocates a free obstacle slot round-robin, picks a lane, and hands the request to the obstacle datapath over a valid/ready handshake. Raises difficulty (level up, interval down) as spawns accumulate. Driven by the game state machine's `game_en`/`game_reset`; sits beside it in `display_top`, feeding the obstacle modules.

## Interface
- `NUM_SLOTS`, 4, number of obstacle slots (≥2)
- `LANE_W`, 3, lane index width
- `INIT_INTERVAL`, 90, frames between spawns after `game_reset` (1..255)
- `MIN_INTERVAL`, 30, interval floor (1..`INIT_INTERVAL`)
- `STEP`, 6, interval decrement per level
- `SPAWNS_PER_LEVEL`, 8, handshakes per level increment
- `LEVEL_W`, 4, level counter width
- `clk`  in  1  clock
- `hard_reset`  in  1  reset; asynchronous, active-high
- `game_reset`  in  1  synchronous clear of all game mechanics
- `game_en`  in  1  high while playing
- `frame_tick`  in  1  one-`clk` pulse per video frame
- `slot_busy`  in  `NUM_SLOTS`  bit i high = slot i occupied
- `spawn_ready`  in  1  datapath accepts request
- `spawn_valid`  out  1  request pending
- `spawn_slot`  out  `NUM_SLOTS`  one-hot target slot
- `spawn_lane`  out  `LANE_W`  lane for new obstacle
- `level`  out  `LEVEL_W`  current difficulty level
- `interval`  out  8  current frames-per-spawn

## Operation
- States: IDLE, WAIT, PICK, ISSUE, STALL.
- IDLE: entered on reset, on `game_reset`, or on `game_en`=0 from any state (next cycle). Moves to WAIT when `game_en`=1. Frame counter cleared.
- WAIT: frame counter increments on `frame_tick`. When a tick makes the counter equal to `interval`, clear the counter and go to PICK.
- PICK (1 cycle): scan `slot_busy` from round-robin pointer `rr`, wrapping. First free slot is latched into `spawn_slot`; lane is latched; go to ISSUE. If all slots are busy, go to STALL.
- STALL: go to PICK in the cycle after any `slot_busy` bit is 0.
- ISSUE: `spawn_valid = (state==ISSUE) & game_en`. A handshake occurs when `spawn_valid & spawn_ready` and sets:
  - `rr` = index after latched slot, modulo `NUM_SLOTS`
  - `spawn_cnt`++
  - When `spawn_cnt` reaches `SPAWNS_PER_LEVEL`:
    - `spawn_cnt` clears.
    - `level`++, saturating at 2^`LEVEL_W`−1.
    - `interval` = max(`interval`−`STEP`, `MIN_INTERVAL`), computed 9-bit signed, no underflow.
  - Next state WAIT.
- `slot_busy` changes during ISSUE are ignored; the latched slot stands.
- `frame_tick` outside WAIT is ignored.
- `game_reset` has priority over all inputs. Clears state to IDLE and clears `rr`, `spawn_cnt`, frame counter, `spawn_slot` and `spawn_lane` to 0, `level` to 0, `interval` to `INIT_INTERVAL`. Does not reseed the LFSR.
- `game_en` low retains `level`/`interval` (gameover display); only `game_reset` clears them.

## Timing
- Reset values:
  - `spawn_valid`, `spawn_slot`, `spawn_lane`, `level` = 0
  - `interval` = `INIT_INTERVAL`
  - state IDLE, LFSR = 16'hACE1
- Latency: `spawn_valid` rises 2 cycles after the qualifying `frame_tick` (PICK, then ISSUE).
- `spawn_valid` falls the cycle after the handshake. `spawn_slot`/`spawn_lane` are stable while valid.
- `spawn_valid` drops combinationally in the same cycle `game_en` falls; no handshake is counted.
- STALL→valid: 2 cycles after a slot frees.

## Configuration
- `SPAWN_RANDOM_EN` defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every `clk`, reset only by `hard_reset`.
  - Lane latched in PICK = `lfsr[LANE_W-1:0]`.
- Undefined: no LFSR; lane = total handshakes modulo 2^`LANE_W` (0,1,2,…), cleared by `game_reset`.

## Structure
- `game_pkg`:
  - game state encodings (init 000, idle 001, playing 010, gameover 100)
  - scheduler state enum
  - LFSR seed/taps constants
- Sub-module `lfsr16` (enable, seed param, 16-bit out), instantiated only under `SPAWN_RANDOM_EN`.
- Round-robin free-slot finder stays inline as a function.

## Test plan
- `hard_reset` pulse mid-ISSUE → all outputs at reset values same cycle; `interval`=90.
- `INIT_INTERVAL`=4, `game_reset` then `game_en`=1, 4 ticks, `slot_busy`=0000 → valid 2 cycles after 4th tick with slot 0001; ready → next spawn slot 0010.
- `slot_busy`=1111 at PICK → STALL, valid 0; set 1011 → valid 2 cycles later, slot 0100.
- 8 handshakes → `level`=1, `interval`=84; continue to 80 handshakes → `interval` floors at 30, `level`=10.
- Valid pending, `spawn_ready`=0, `game_en` falls → valid 0 that cycle, state IDLE, `spawn_cnt` unchanged; `game_reset` → `level`=0, `interval`=90.
- Macro off: lanes 0,1,2,3 on successive spawns. Macro on: lanes match a reference LFSR model from seed ACE1.
